// File: rtl/instr_encoder.sv
// instr_encoder: assembles instruction words from field requests and streams them into instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_class,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              illegal,
  output logic              err_sticky
);
  typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0] enc;
  logic last, done, acc, legal;
  assign last = &addr;
  assign done = state == HOLD && mem_ready;
  assign req_ready = state == IDLE || (done && !last);
  assign acc = req_valid && req_ready;
  assign legal = req_class != 3'd7;
  assign mem_we = state == HOLD;
  assign mem_addr = addr;
  assign full = state == FULL;
  // class 7 (bgezal) falls through to the jsp encoding but is never registered
  always_comb
    enc = req_class == 3'd0 ? {6'b000000, req_rs, req_rt, req_rd, req_shamt, req_funct} :
          req_class == 3'd1 ? {6'b100011, req_rs, req_rt, req_imm} :
          req_class == 3'd2 ? {6'b101011, req_rs, req_rt, req_imm} :
          req_class == 3'd3 ? {6'b000100, req_rs, req_rt, req_imm} :
          req_class == 3'd4 ? {6'b010000, req_rs, req_rt, req_imm} :
          req_class == 3'd5 ? {6'b011011, req_target} :
                              {6'b010010, req_rs, 21'b0};
  always_comb
    state_n = done ? (last ? FULL : (acc && legal ? HOLD : IDLE)) :
              (state == IDLE && acc && legal) ? HOLD : state;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      mem_wdata  <= '0;
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_n;
      if (done) count <= count + (ADDR_W+1)'(1);
      if (done && !last) addr <= addr + ADDR_W'(1);
      if (acc && legal) mem_wdata <= enc;
      illegal    <= acc && !legal;
      err_sticky <= err_sticky || (acc && !legal);
    end
  end
endmodule
